// File: rtl/count_pkg.sv
// Shared types and defaults for the count sequencer and its step datapath.
package count_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_WRAP_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    INC  = 2'd2,
    ONES = 2'd3
  } step_sel_t;

  // Configuration is only accepted while the counter is parked.
  function automatic logic is_parked(state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/count_step.sv
// Combinational next-value datapath: hold, load, increment (mod 2^WIDTH) or all ones.
module count_step
  import count_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    case (step_sel_t'(sel))
      HOLD:    next_q = q;
      LOAD:    next_q = load_val;
      INC:     next_q = q + WIDTH'(1);
      ONES:    next_q = '1;
      default: next_q = q;
    endcase
  end

endmodule

// File: rtl/count_sequencer.sv
// Counter controller: configure / run / pause / terminal-count sequencing around count_step.
module count_sequencer
  import count_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int AUTO_RELOAD = 0,
  parameter int WRAP_W      = DEFAULT_WRAP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_load,
  input  logic [WIDTH-1:0]  cfg_limit,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              force_ones,
  output logic [WIDTH-1:0]  count_q,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [1:0]        fsm_state
);

  state_t            state;
  state_t            state_nxt;
  step_sel_t         sel;
  logic              accept;
  logic              term_hit;
  logic [WIDTH-1:0]  load_r;
  logic [WIDTH-1:0]  limit_r;
  logic [WIDTH-1:0]  step_load;
  logic [WIDTH-1:0]  next_q;

  // Handshake: a configuration transfers on any rising edge where cfg_valid and
  // cfg_ready are both high; cfg_ready depends only on state, never on cfg_valid.
  assign cfg_ready = is_parked(state);
  assign busy      = (state == RUN) || (state == PAUSE);
  assign accept    = cfg_valid && cfg_ready;
  assign fsm_state = state;

  // An accepted configuration loads the counter directly from the offered value.
  assign step_load = accept ? cfg_load : load_r;

  always_comb begin
    state_nxt = state;
    sel       = HOLD;
    term_hit  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          sel = LOAD;
        end else if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (force_ones) begin
          sel = ONES;
        end else if (pause) begin
          state_nxt = PAUSE;
        end else if (count_q == limit_r) begin
          term_hit = 1'b1;
          if (AUTO_RELOAD != 0) begin
            sel = LOAD;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          sel = INC;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          if (force_ones) begin
            sel = ONES;
          end
          // Leaving PAUSE costs one cycle with no count.
          if (!pause) begin
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  count_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q        (count_q),
    .load_val (step_load),
    .sel      (sel),
    .next_q   (next_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count_q  <= '0;
      load_r   <= '0;
      limit_r  <= '1;
      done     <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      count_q <= next_q;
      done    <= term_hit;
      if (accept) begin
        load_r   <= cfg_load;
        limit_r  <= cfg_limit;
        wrap_cnt <= '0;
      end else if (term_hit && (wrap_cnt != {WRAP_W{1'b1}})) begin
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed + randomized bench for count_sequencer (one-shot and auto-reload instances).
module tb_count_sequencer;
  import count_pkg::*;

  localparam int W  = 16;
  localparam int WW = 8;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  // ---------------- clock / reset / stimulus signals ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic [W-1:0]  cfg_load;
  logic [W-1:0]  cfg_limit;
  logic          start;
  logic          stop;
  logic          pause;
  logic          force_ones;

  logic          ready_a, busy_a, done_a;
  logic [W-1:0]  count_a;
  logic [WW-1:0] wrap_a;
  logic [1:0]    fsm_a;
  logic          ready_b, busy_b, done_b;
  logic [W-1:0]  count_b;
  logic [WW-1:0] wrap_b;
  logic [1:0]    fsm_b;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(W), .AUTO_RELOAD(0), .WRAP_W(WW)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
    .cfg_load(cfg_load), .cfg_limit(cfg_limit), .start(start), .stop(stop),
    .pause(pause), .force_ones(force_ones), .count_q(count_a), .busy(busy_a),
    .done(done_a), .wrap_cnt(wrap_a), .fsm_state(fsm_a)
  );

  count_sequencer #(.WIDTH(W), .AUTO_RELOAD(1), .WRAP_W(WW)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
    .cfg_load(cfg_load), .cfg_limit(cfg_limit), .start(start), .stop(stop),
    .pause(pause), .force_ones(force_ones), .count_q(count_b), .busy(busy_b),
    .done(done_b), .wrap_cnt(wrap_b), .fsm_state(fsm_b)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int st;
    int cnt;
    int ld;
    int lim;
    int wrap;
    bit done;
  } model_t;

  model_t ma;
  model_t mb;

  function automatic model_t model_reset();
    model_t n;
    n.st   = M_IDLE;
    n.cnt  = 0;
    n.ld   = 0;
    n.lim  = (1 << W) - 1;
    n.wrap = 0;
    n.done = 1'b0;
    return n;
  endfunction

  function automatic model_t model_step(model_t m, bit auto_rl);
    model_t n;
    n = m;
    n.done = 1'b0;
    if (m.st == M_IDLE || m.st == M_DONE) begin
      if (cfg_valid) begin
        n.ld = int'(cfg_load);
        n.lim = int'(cfg_limit);
        n.cnt = int'(cfg_load);
        n.wrap = 0;
      end else if (stop) begin
        n.st = M_IDLE;
      end else if (start) begin
        n.st = M_RUN;
      end
    end else if (m.st == M_RUN) begin
      if (stop) n.st = M_IDLE;
      else if (force_ones) n.cnt = (1 << W) - 1;
      else if (pause) n.st = M_PAUSE;
      else if (m.cnt == m.lim) begin
        n.done = 1'b1;
        n.wrap = (m.wrap + 1 > (1 << WW) - 1) ? (1 << WW) - 1 : m.wrap + 1;
        if (auto_rl) n.cnt = m.ld;
        else n.st = M_DONE;
      end else begin
        n.cnt = (m.cnt + 1) % (1 << W);
      end
    end else begin
      if (stop) n.st = M_IDLE;
      else begin
        if (force_ones) n.cnt = (1 << W) - 1;
        if (!pause) n.st = M_RUN;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= model_step(ma, 1'b0);
      mb <= model_step(mb, 1'b1);
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("a_count", 32'(count_a), 32'(ma.cnt));
    check("a_done",  32'(done_a),  32'(ma.done));
    check("a_busy",  32'(busy_a),  32'(ma.st == M_RUN || ma.st == M_PAUSE));
    check("a_ready", 32'(ready_a), 32'(ma.st == M_IDLE || ma.st == M_DONE));
    check("a_wrap",  32'(wrap_a),  32'(ma.wrap));
    check("b_count", 32'(count_b), 32'(mb.cnt));
    check("b_done",  32'(done_b),  32'(mb.done));
    check("b_busy",  32'(busy_b),  32'(mb.st == M_RUN || mb.st == M_PAUSE));
    check("b_ready", 32'(ready_b), 32'(mb.st == M_IDLE || mb.st == M_DONE));
    check("b_wrap",  32'(wrap_b),  32'(mb.wrap));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic cfg(input logic [W-1:0] ld, input logic [W-1:0] lim);
    cfg_valid = 1'b1;
    cfg_load  = ld;
    cfg_limit = lim;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_load = '0; cfg_limit = '0;
    start = 1'b0; stop = 1'b0; pause = 1'b0; force_ones = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count_a), 32'h0);
    check("rst_busy",  32'(busy_a),  32'h0);
    check("rst_done",  32'(done_a),  32'h0);
    check("rst_wrap",  32'(wrap_a),  32'h0);
    check("rst_ready", 32'(ready_a), 32'h1);
    check("rst_state", 32'(fsm_a),   32'(IDLE));
    rst_n = 1'b1;
    cyc();

    // One-shot: load 5, limit 8
    cfg(16'd5, 16'd8);
    check("t1_load", 32'(count_a), 32'd5);
    pulse_start();
    check("t1_run", 32'(fsm_a), 32'(RUN));
    for (int i = 5; i <= 8; i++) exp_q.push_back(W'(i));
    check("t1_seq", 32'(count_a), 32'(exp_q.pop_front()));
    while (exp_q.size() > 0) begin
      cyc();
      check("t1_seq", 32'(count_a), 32'(exp_q.pop_front()));
    end
    check("t1_no_early_done", 32'(done_a), 32'h0);
    cyc();
    check("t1_done",  32'(done_a),  32'h1);
    check("t1_state", 32'(fsm_a),   32'(DONE));
    check("t1_hold",  32'(count_a), 32'd8);
    check("t1_wrap",  32'(wrap_a),  32'd1);
    cyc();
    check("t1_done_pulse", 32'(done_a), 32'h0);
    pulse_stop();

    // Auto-reload FFFE..FFFF and wrap counter saturation
    cfg(16'hFFFE, 16'hFFFF);
    pulse_start();
    check("t2_first", 32'(count_b), 32'hFFFE);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t2_seq",  32'(count_b), (i % 2 == 0) ? 32'hFFFF : 32'hFFFE);
      check("t2_done", 32'(done_b),  32'(i % 2));
    end
    repeat (510) cyc();
    check("t2_wrap_sat", 32'(wrap_b), 32'hFF);
    check("t2_a_done",   32'(fsm_a),  32'(DONE));
    pulse_stop();

    // Wrap through zero: FFFF, 0000, 0001 then DONE
    cfg(16'hFFFF, 16'h0001);
    pulse_start();
    exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    check("t3_seq", 32'(count_a), 32'(exp_q.pop_front()));
    while (exp_q.size() > 0) begin
      cyc();
      check("t3_seq", 32'(count_a), 32'(exp_q.pop_front()));
    end
    cyc();
    check("t3_done",  32'(done_a), 32'h1);
    check("t3_state", 32'(fsm_a),  32'(DONE));
    pulse_stop();

    // Pause at 3 for 4 cycles, bubble, then 4
    cfg(16'd0, 16'd100);
    pulse_start();
    repeat (3) cyc();
    check("t4_at3", 32'(count_a), 32'd3);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t4_hold", 32'(count_a), 32'd3);
      check("t4_busy", 32'(busy_a),  32'h1);
    end
    check("t4_paused", 32'(fsm_a), 32'(PAUSE));
    pause = 1'b0;
    cyc();
    check("t4_bubble", 32'(count_a), 32'd3);
    cyc();
    check("t4_resume", 32'(count_a), 32'd4);

    // Configuration refused while running; stop at 6 then accept
    cfg_valid = 1'b1; cfg_load = 16'h55; cfg_limit = 16'h60;
    check("t5_not_ready", 32'(ready_a), 32'h0);
    cyc();
    check("t5_ignored", 32'(count_a), 32'd5);
    cyc();
    check("t5_at6", 32'(count_a), 32'd6);
    cfg_valid = 1'b0;
    pulse_stop();
    check("t5_stop_cnt",   32'(count_a), 32'd6);
    check("t5_stop_ready", 32'(ready_a), 32'h1);
    check("t5_stop_state", 32'(fsm_a),   32'(IDLE));
    cfg(16'h55, 16'h60);
    check("t5_accept", 32'(count_a), 32'h55);

    // force_ones with limit FFFF
    cfg(16'h10, 16'hFFFF);
    pulse_start();
    force_ones = 1'b1;
    cyc();
    force_ones = 1'b0;
    check("t6_ones", 32'(count_a), 32'hFFFF);
    check("t6_no_done_yet", 32'(done_a), 32'h0);
    cyc();
    check("t6_done",  32'(done_a), 32'h1);
    check("t6_state", 32'(fsm_a),  32'(DONE));
    pulse_stop();

    // Asynchronous reset mid-run
    cfg(16'd0, 16'd100);
    pulse_start();
    repeat (2) cyc();
    check("t7_running", 32'(count_a), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_cnt",   32'(count_a), 32'h0);
    check("t7_async_busy",  32'(busy_a),  32'h0);
    check("t7_async_state", 32'(fsm_a),   32'(IDLE));
    check("t7_async_done",  32'(done_a),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("t7_after_done", 32'(done_a), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cfg_valid  = ($urandom_range(0, 7) == 0);
      cfg_load   = ($urandom_range(0, 3) == 0) ? W'(16'hFFF8 + $urandom_range(0, 7))
                                               : W'($urandom_range(0, 12));
      cfg_limit  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : W'($urandom_range(0, 12));
      start      = ($urandom_range(0, 2) == 0);
      stop       = ($urandom_range(0, 24) == 0);
      pause      = ($urandom_range(0, 5) == 0);
      force_ones = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #1 compare_all();
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
